// File: rtl/sha2_pad.sv
// rtl/sha2_pad.sv - SHA-2 message padder: 0x80 marker, zero fill, bit-length trailer.
// Optional sticky protocol error checking is built when SHA2_PAD_ERR_EN is defined.
module sha2_pad #(
  parameter int L_WIDTH = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [1:0]   in_mode_i,
  input  logic [63:0]  in_data_i,
  input  logic [3:0]   in_bytes_i,
  input  logic         in_last_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [63:0]  out_data_o,
  output logic         out_last_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         err_o
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_ZERO, S_LEN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_wide, w_wide_nxt;
  logic               r_first, w_first_nxt;
  logic [3:0]         r_wcnt, w_wcnt_nxt;
  logic [L_WIDTH-1:0] r_len, w_len_nxt;
  logic [63:0]        r_out_data, w_out_data_nxt;
  logic               r_out_last, w_out_last_nxt;
  logic               r_out_valid, w_out_valid_nxt;

  logic               w_load;
  logic               w_accept;
  logic               w_wide;
  logic [3:0]         w_last_idx;
  logic [3:0]         w_slot;
  logic [3:0]         w_wcnt_inc;
  logic [3:0]         w_bytes;
  logic [63:0]        w_keep;
  logic [63:0]        w_mark;
  logic [63:0]        w_padded;
  logic [63:0]        w_len_ext;
  state_t             w_mark_next;
  logic               w_unused;

  assign w_unused   = in_mode_i[0];
  assign w_load     = ~r_out_valid | out_ready_i;
  assign in_ready_o = (r_state == S_DATA) & w_load;
  assign w_accept   = in_valid_i & in_ready_o;

  // Mode is taken live on the first word of a message, latched afterwards.
  assign w_wide     = r_first ? in_mode_i[1] : r_wide;
  assign w_last_idx = w_wide ? 4'd15 : 4'd7;
  assign w_slot     = w_wide ? 4'd14 : 4'd7;
  assign w_wcnt_inc = (r_wcnt == w_last_idx) ? 4'd0 : r_wcnt + 4'd1;
  assign w_bytes    = (in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i;

  assign w_keep     = ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_bytes[2:0], 3'b000});
  assign w_mark     = 64'h80 << {~w_bytes[2:0], 3'b000};
  assign w_padded   = (in_data_i & w_keep) | w_mark;
  assign w_len_ext  = 64'(r_len);
  assign w_mark_next = (w_wcnt_inc == w_slot) ? S_LEN : S_ZERO;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_wide      <= 1'b0;
      r_first     <= 1'b1;
      r_wcnt      <= 4'd0;
      r_len       <= '0;
      r_out_data  <= 64'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wide      <= w_wide_nxt;
      r_first     <= w_first_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_len       <= w_len_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wide_nxt      = r_wide;
    w_first_nxt     = r_first;
    w_wcnt_nxt      = r_wcnt;
    w_len_nxt       = r_len;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_valid_nxt = r_out_valid;
    if (w_load) begin
      w_out_valid_nxt = 1'b0;
      w_out_last_nxt  = 1'b0;
    end
    case (r_state)
      S_IDLE: w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_accept) begin
          w_out_valid_nxt = 1'b1;
          w_wcnt_nxt      = w_wcnt_inc;
          w_first_nxt     = 1'b0;
          w_wide_nxt      = w_wide;
          if (!in_last_i) begin
            w_out_data_nxt = in_data_i;
            w_len_nxt      = r_len + L_WIDTH'(64);
          end else begin
            w_len_nxt = r_len + L_WIDTH'({w_bytes, 3'b000});
            if (w_bytes == 4'd8) begin
              w_out_data_nxt = in_data_i;
              w_state_nxt    = S_PAD;
            end else begin
              w_out_data_nxt = w_padded;
              w_state_nxt    = w_mark_next;
            end
          end
        end
      end
      S_PAD: begin
        if (w_load) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = 64'h8000_0000_0000_0000;
          w_wcnt_nxt      = w_wcnt_inc;
          w_state_nxt     = w_mark_next;
        end
      end
      S_ZERO: begin
        if (w_load) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = 64'd0;
          w_wcnt_nxt      = w_wcnt_inc;
          w_state_nxt     = w_mark_next;
        end
      end
      S_LEN: begin
        if (w_load) begin
          w_out_valid_nxt = 1'b1;
          // 1024-bit blocks carry a 128-bit length; its upper word is always 0.
          if (r_wide && (r_wcnt == 4'd14)) begin
            w_out_data_nxt = 64'd0;
            w_wcnt_nxt     = 4'd15;
          end else begin
            w_out_data_nxt = w_len_ext;
            w_out_last_nxt = 1'b1;
            w_wcnt_nxt     = 4'd0;
            w_len_nxt      = '0;
            w_first_nxt    = 1'b1;
            w_state_nxt    = S_DATA;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign out_valid_o = r_out_valid;

`ifdef SHA2_PAD_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = w_accept & ((in_bytes_i > 4'd8) |
                     (in_last_i & (in_bytes_i == 4'd0) & (r_len != '0)));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule
